// File: rtl/jtbubl_snd_comm.sv
// Main CPU <-> sound CPU mailbox: one command byte (main -> sound), one reply
// byte (sound -> main), pending/overrun flags, a gated NMI to the sound CPU
// and a sound-CPU reset pulse whose length the main CPU can trigger.
module jtbubl_snd_comm #(
    parameter int RSTLEN = 16
) (
    input  logic       clk24,
    input  logic       rst,
    input  logic       main_cs,
    input  logic       main_rnw,
    input  logic [1:0] main_addr,
    input  logic [7:0] main_dout,
    output logic [7:0] main_din,
    input  logic       snd_cs,
    input  logic       snd_rnw,
    input  logic [1:0] snd_addr,
    input  logic [7:0] snd_dout,
    output logic [7:0] snd_din,
    output logic       snd_nmi_n,
    output logic       snd_rst
);

    localparam logic [7:0] LP_RSTLEN = 8'(RSTLEN);

    logic       r_main_cs_q;
    logic       r_snd_cs_q;
    logic [7:0] r_cmd_latch;
    logic       r_cmd_pend;
    logic       r_cmd_ovr;
    logic [7:0] r_rep_latch;
    logic       r_rep_pend;
    logic       r_rep_ovr;
    logic       r_nmi_req;
    logic       r_nmi_en;
    logic [7:0] r_rst_cnt;
    logic       r_snd_nmi_n;

    // An access is the first cycle of a cs pulse; holding cs does nothing more.
    logic w_main_ev;
    logic w_snd_ev;
    assign w_main_ev = main_cs & ~r_main_cs_q;
    assign w_snd_ev  = snd_cs  & ~r_snd_cs_q;

    logic w_m_wr0, w_m_rd0, w_m_rd1, w_m_srst;
    assign w_m_wr0  = w_main_ev & ~main_rnw & (main_addr == 2'd0);
    assign w_m_rd0  = w_main_ev &  main_rnw & (main_addr == 2'd0);
    assign w_m_rd1  = w_main_ev &  main_rnw & (main_addr == 2'd1);
    assign w_m_srst = w_main_ev & ~main_rnw & (main_addr == 2'd2) & main_dout[0];

    logic w_s_rd0, w_s_wr0, w_s_wr1, w_s_wr2, w_s_rd3;
    assign w_s_rd0 = w_snd_ev &  snd_rnw & (snd_addr == 2'd0);
    assign w_s_wr0 = w_snd_ev & ~snd_rnw & (snd_addr == 2'd0);
    assign w_s_wr1 = w_snd_ev & ~snd_rnw & (snd_addr == 2'd1);
    assign w_s_wr2 = w_snd_ev & ~snd_rnw & (snd_addr == 2'd2);
    assign w_s_rd3 = w_snd_ev &  snd_rnw & (snd_addr == 2'd3);

    // Mailbox, NMI and reset-counter state. Later assignments in this block
    // take priority: a sound-CPU reset overrides flags set in the same cycle.
    always_ff @(posedge clk24) begin
        if (rst) begin
            r_main_cs_q <= 1'b0;
            r_snd_cs_q  <= 1'b0;
            r_cmd_latch <= 8'h00;
            r_cmd_pend  <= 1'b0;
            r_cmd_ovr   <= 1'b0;
            r_rep_latch <= 8'h00;
            r_rep_pend  <= 1'b0;
            r_rep_ovr   <= 1'b0;
            r_nmi_req   <= 1'b0;
            r_nmi_en    <= 1'b0;
            r_rst_cnt   <= LP_RSTLEN;
            r_snd_nmi_n <= 1'b1;
        end else begin
            r_main_cs_q <= main_cs;
            r_snd_cs_q  <= snd_cs;
            r_snd_nmi_n <= ~(r_nmi_req & r_nmi_en);

            // Command path: a write arriving with a simultaneous read wins
            // the pending flag and is not counted as an overrun.
            if (w_m_wr0) begin
                r_cmd_latch <= main_dout;
                r_cmd_pend  <= 1'b1;
                r_nmi_req   <= 1'b1;
            end else if (w_s_rd0) begin
                r_cmd_pend  <= 1'b0;
                r_nmi_req   <= 1'b0;
            end
            if (w_m_wr0 & r_cmd_pend & ~w_s_rd0)
                r_cmd_ovr <= 1'b1;
            else if (w_m_rd1)
                r_cmd_ovr <= 1'b0;

            // Reply path mirrors the command path in the other direction.
            if (w_s_wr0) begin
                r_rep_latch <= snd_dout;
                r_rep_pend  <= 1'b1;
            end else if (w_m_rd0) begin
                r_rep_pend  <= 1'b0;
            end
            if (w_s_wr0 & r_rep_pend & ~w_m_rd0)
                r_rep_ovr <= 1'b1;
            else if (w_s_rd3)
                r_rep_ovr <= 1'b0;

            if (w_s_wr2)
                r_nmi_en <= 1'b1;
            else if (w_s_wr1)
                r_nmi_en <= 1'b0;

            if (w_m_srst) begin
                r_rst_cnt  <= LP_RSTLEN;
                r_cmd_pend <= 1'b0;
                r_nmi_req  <= 1'b0;
                r_nmi_en   <= 1'b0;
                r_rep_pend <= 1'b0;
                r_rep_ovr  <= 1'b0;
            end else if (r_rst_cnt != 8'd0) begin
                r_rst_cnt  <= r_rst_cnt - 8'd1;
            end
        end
    end

    // Read data is combinational from the current register state.
    always_comb begin
        main_din = 8'hFF;
        snd_din  = 8'hFF;
        if (main_cs & main_rnw) begin
            case (main_addr)
                2'd0:    main_din = r_rep_latch;
                2'd1:    main_din = {4'b0, r_rep_ovr, r_cmd_ovr, r_rep_pend, r_cmd_pend};
                default: main_din = 8'hFF;
            endcase
        end
        if (snd_cs & snd_rnw) begin
            case (snd_addr)
                2'd0:    snd_din = r_cmd_latch;
                2'd3:    snd_din = {6'b0, r_rep_pend, r_cmd_pend};
                default: snd_din = 8'hFF;
            endcase
        end
    end

    assign snd_nmi_n = r_snd_nmi_n;
    assign snd_rst   = (r_rst_cnt != 8'd0);

endmodule

// File: tb/tb_jtbubl_snd_comm.sv
// Bench for jtbubl_snd_comm: directed scenarios with fixed expected values,
// then random traffic on both CPU ports checked against a mailbox model.
module tb_jtbubl_snd_comm;

    localparam int RSTLEN = 16;

    logic       clk24 = 1'b0;
    logic       rst = 1'b1;
    logic       main_cs = 1'b0, main_rnw = 1'b1;
    logic [1:0] main_addr = 2'd0;
    logic [7:0] main_dout = 8'h00;
    logic [7:0] main_din;
    logic       snd_cs = 1'b0, snd_rnw = 1'b1;
    logic [1:0] snd_addr = 2'd0;
    logic [7:0] snd_dout = 8'h00;
    logic [7:0] snd_din;
    logic       snd_nmi_n;
    logic       snd_rst;

    int n_checks = 0;
    int n_fail   = 0;

    jtbubl_snd_comm #(.RSTLEN(RSTLEN)) dut (
        .clk24(clk24), .rst(rst),
        .main_cs(main_cs), .main_rnw(main_rnw), .main_addr(main_addr),
        .main_dout(main_dout), .main_din(main_din),
        .snd_cs(snd_cs), .snd_rnw(snd_rnw), .snd_addr(snd_addr),
        .snd_dout(snd_dout), .snd_din(snd_din),
        .snd_nmi_n(snd_nmi_n), .snd_rst(snd_rst)
    );

    // Clock
    always #5 clk24 = ~clk24;

    // Mailbox model, advanced once per clock from the inputs the DUT samples.
    logic [7:0] m_cmd = 8'h00, m_rep = 8'h00;
    logic m_cpend = 1'b0, m_covr = 1'b0, m_rpend = 1'b0, m_rovr = 1'b0;
    logic m_nreq = 1'b0, m_nen = 1'b0, m_nmi_n = 1'b1;
    logic m_main_prev = 1'b0, m_snd_prev = 1'b0;
    int   m_cnt = RSTLEN;

    task automatic model_step();
        bit mev, sev, mw0, mr0, mr1, msr, sr0, sw0, sw1, sw2, sr3;
        if (rst) begin
            m_cmd = 8'h00; m_rep = 8'h00;
            m_cpend = 0; m_covr = 0; m_rpend = 0; m_rovr = 0;
            m_nreq = 0; m_nen = 0; m_nmi_n = 1; m_cnt = RSTLEN;
            m_main_prev = 0; m_snd_prev = 0;
            return;
        end
        mev = main_cs && !m_main_prev;
        sev = snd_cs && !m_snd_prev;
        mw0 = mev && !main_rnw && main_addr == 2'd0;
        mr0 = mev && main_rnw && main_addr == 2'd0;
        mr1 = mev && main_rnw && main_addr == 2'd1;
        msr = mev && !main_rnw && main_addr == 2'd2 && main_dout[0];
        sr0 = sev && snd_rnw && snd_addr == 2'd0;
        sw0 = sev && !snd_rnw && snd_addr == 2'd0;
        sw1 = sev && !snd_rnw && snd_addr == 2'd1;
        sw2 = sev && !snd_rnw && snd_addr == 2'd2;
        sr3 = sev && snd_rnw && snd_addr == 2'd3;
        // NMI line shows the request/enable pair as it stood before this edge
        m_nmi_n = !(m_nreq && m_nen);
        // overrun flags: clear first, so a same-cycle set survives
        if (mr1) m_covr = 0;
        if (sr3) m_rovr = 0;
        // a new command is lost-over only if the old one was never consumed
        if (mw0) begin
            if (m_cpend && !sr0) m_covr = 1;
            m_cmd = main_dout; m_cpend = 1; m_nreq = 1;
        end else if (sr0) begin
            m_cpend = 0; m_nreq = 0;
        end
        if (sw0) begin
            if (m_rpend && !mr0) m_rovr = 1;
            m_rep = snd_dout; m_rpend = 1;
        end else if (mr0) begin
            m_rpend = 0;
        end
        if (sw2) m_nen = 1;
        if (sw1) m_nen = 0;
        if (msr) begin
            m_cnt = RSTLEN;
            m_cpend = 0; m_nreq = 0; m_nen = 0; m_rpend = 0; m_rovr = 0;
        end else if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
        end
        m_main_prev = main_cs;
        m_snd_prev = snd_cs;
    endtask

    function automatic logic [7:0] exp_main_din();
        if (!(main_cs && main_rnw)) return 8'hFF;
        if (main_addr == 2'd0) return m_rep;
        if (main_addr == 2'd1) return {4'b0, m_rovr, m_covr, m_rpend, m_cpend};
        return 8'hFF;
    endfunction

    function automatic logic [7:0] exp_snd_din();
        if (!(snd_cs && snd_rnw)) return 8'hFF;
        if (snd_addr == 2'd0) return m_cmd;
        if (snd_addr == 2'd3) return {6'b0, m_rpend, m_cpend};
        return 8'hFF;
    endfunction

    // Drivers: one clock edge, inputs change 1 ns after the edge
    task automatic tick();
        model_step();
        @(posedge clk24);
        #1;
    endtask

    task automatic main_wr(input logic [1:0] a, input logic [7:0] d);
        main_cs = 1; main_rnw = 0; main_addr = a; main_dout = d;
        tick();
        main_cs = 0; main_rnw = 1;
        tick();
    endtask

    task automatic main_rd(input logic [1:0] a, output logic [7:0] d);
        main_cs = 1; main_rnw = 1; main_addr = a;
        #1 d = main_din;
        tick();
        main_cs = 0;
        tick();
    endtask

    task automatic snd_wr(input logic [1:0] a, input logic [7:0] d);
        snd_cs = 1; snd_rnw = 0; snd_addr = a; snd_dout = d;
        tick();
        snd_cs = 0; snd_rnw = 1;
        tick();
    endtask

    task automatic snd_rd(input logic [1:0] a, output logic [7:0] d);
        snd_cs = 1; snd_rnw = 1; snd_addr = a;
        #1 d = snd_din;
        tick();
        snd_cs = 0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1;
        tick(); tick();
        rst = 0;
        #1;
        n_checks++; if (snd_nmi_n !== 1'b1) begin n_fail++; $display("FAIL reset_nmi: snd_nmi_n=%b expected 1", snd_nmi_n); end
        main_cs = 1; main_rnw = 1; main_addr = 2'd1;
        #1;
        n_checks++; if (main_din !== 8'h00) begin n_fail++; $display("FAIL reset_status: main_din=%h expected 00", main_din); end
        for (int i = 0; i < RSTLEN; i++) begin
            n_checks++; if (snd_rst !== 1'b1) begin n_fail++; $display("FAIL reset_len[%0d]: snd_rst=%b expected 1", i, snd_rst); end
            tick();
            main_cs = 0;
        end
        n_checks++; if (snd_rst !== 1'b0) begin n_fail++; $display("FAIL reset_end: snd_rst=%b expected 0", snd_rst); end
    endtask

    task automatic test_cmd_nmi();
        logic [7:0] d;
        snd_wr(2'd2, 8'h00);
        main_cs = 1; main_rnw = 0; main_addr = 2'd0; main_dout = 8'h5A;
        tick();
        n_checks++; if (snd_nmi_n !== 1'b1) begin n_fail++; $display("FAIL nmi_early: snd_nmi_n=%b expected 1", snd_nmi_n); end
        main_cs = 0; main_rnw = 1;
        tick();
        n_checks++; if (snd_nmi_n !== 1'b0) begin n_fail++; $display("FAIL nmi_assert: snd_nmi_n=%b expected 0", snd_nmi_n); end
        snd_rd(2'd0, d);
        n_checks++; if (d !== 8'h5A) begin n_fail++; $display("FAIL cmd_read: snd_din=%h expected 5a", d); end
        n_checks++; if (snd_nmi_n !== 1'b1) begin n_fail++; $display("FAIL nmi_release: snd_nmi_n=%b expected 1", snd_nmi_n); end
        main_rd(2'd1, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL cmd_status: main_din=%h expected 00", d); end
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        main_wr(2'd0, 8'h11);
        main_wr(2'd0, 8'h22);
        main_rd(2'd1, d);
        n_checks++; if (d !== 8'h05) begin n_fail++; $display("FAIL ovr_status: main_din=%h expected 05", d); end
        snd_rd(2'd0, d);
        n_checks++; if (d !== 8'h22) begin n_fail++; $display("FAIL ovr_data: snd_din=%h expected 22", d); end
        main_rd(2'd1, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL ovr_cleared: main_din=%h expected 00", d); end
    endtask

    task automatic test_nmi_disable();
        logic [7:0] d;
        snd_wr(2'd1, 8'h00);
        main_wr(2'd0, 8'h33);
        tick();
        n_checks++; if (snd_nmi_n !== 1'b1) begin n_fail++; $display("FAIL nmi_masked: snd_nmi_n=%b expected 1", snd_nmi_n); end
        snd_cs = 1; snd_rnw = 0; snd_addr = 2'd2;
        tick();
        n_checks++; if (snd_nmi_n !== 1'b1) begin n_fail++; $display("FAIL nmi_en_early: snd_nmi_n=%b expected 1", snd_nmi_n); end
        snd_cs = 0; snd_rnw = 1;
        tick();
        n_checks++; if (snd_nmi_n !== 1'b0) begin n_fail++; $display("FAIL nmi_enable: snd_nmi_n=%b expected 0", snd_nmi_n); end
        snd_rd(2'd0, d);
        n_checks++; if (d !== 8'h33) begin n_fail++; $display("FAIL nmi_cmd: snd_din=%h expected 33", d); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        // command written and read in the same cycle
        main_wr(2'd0, 8'h44);
        main_cs = 1; main_rnw = 0; main_addr = 2'd0; main_dout = 8'h55;
        snd_cs = 1; snd_rnw = 1; snd_addr = 2'd0;
        #1;
        n_checks++; if (snd_din !== 8'h44) begin n_fail++; $display("FAIL simul_cmd_old: snd_din=%h expected 44", snd_din); end
        tick();
        main_cs = 0; main_rnw = 1; snd_cs = 0;
        tick();
        main_rd(2'd1, d);
        n_checks++; if (d !== 8'h01) begin n_fail++; $display("FAIL simul_cmd_status: main_din=%h expected 01", d); end
        snd_rd(2'd0, d);
        n_checks++; if (d !== 8'h55) begin n_fail++; $display("FAIL simul_cmd_new: snd_din=%h expected 55", d); end
        // reply written and read in the same cycle
        snd_wr(2'd0, 8'h66);
        snd_cs = 1; snd_rnw = 0; snd_addr = 2'd0; snd_dout = 8'h77;
        main_cs = 1; main_rnw = 1; main_addr = 2'd0;
        #1;
        n_checks++; if (main_din !== 8'h66) begin n_fail++; $display("FAIL simul_rep_old: main_din=%h expected 66", main_din); end
        tick();
        snd_cs = 0; snd_rnw = 1; main_cs = 0;
        tick();
        main_rd(2'd1, d);
        n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL simul_rep_status: main_din=%h expected 02", d); end
        main_rd(2'd0, d);
        n_checks++; if (d !== 8'h77) begin n_fail++; $display("FAIL simul_rep_new: main_din=%h expected 77", d); end
        main_rd(2'd1, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL simul_rep_clear: main_din=%h expected 00", d); end
    endtask

    task automatic test_hold_and_snd_reset();
        logic [7:0] d;
        snd_wr(2'd0, 8'hC3);
        main_cs = 1; main_rnw = 1; main_addr = 2'd0;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                #1;
                n_checks++; if (main_din !== 8'hC3) begin n_fail++; $display("FAIL hold_read: main_din=%h expected c3", main_din); end
            end
            if (i == 2) begin snd_cs = 1; snd_rnw = 0; snd_addr = 2'd0; snd_dout = 8'hD2; end
            if (i == 3) begin snd_cs = 0; snd_rnw = 1; end
            tick();
        end
        main_cs = 0;
        tick();
        main_rd(2'd1, d);
        n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL hold_once: main_din=%h expected 02", d); end
        main_rd(2'd0, d);
        n_checks++; if (d !== 8'hD2) begin n_fail++; $display("FAIL hold_rep2: main_din=%h expected d2", d); end
        // writes with bit 0 clear and unmapped accesses do nothing
        main_wr(2'd2, 8'hFE);
        main_wr(2'd3, 8'h01);
        n_checks++; if (snd_rst !== 1'b0) begin n_fail++; $display("FAIL srst_bit0: snd_rst=%b expected 0", snd_rst); end
        main_rd(2'd3, d);
        n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL main_unmapped: main_din=%h expected ff", d); end
        snd_rd(2'd1, d);
        n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL snd_unmapped: snd_din=%h expected ff", d); end
        n_checks++; if (main_din !== 8'hFF) begin n_fail++; $display("FAIL main_idle: main_din=%h expected ff", main_din); end
        // sound-CPU reset pulse from the main side
        snd_wr(2'd2, 8'h00);
        main_wr(2'd0, 8'h99);
        n_checks++; if (snd_nmi_n !== 1'b0) begin n_fail++; $display("FAIL srst_pre_nmi: snd_nmi_n=%b expected 0", snd_nmi_n); end
        main_cs = 1; main_rnw = 0; main_addr = 2'd2; main_dout = 8'h01;
        tick();
        main_cs = 0; main_rnw = 1;
        for (int i = 0; i < RSTLEN; i++) begin
            n_checks++; if (snd_rst !== 1'b1) begin n_fail++; $display("FAIL srst_len[%0d]: snd_rst=%b expected 1", i, snd_rst); end
            if (i == 4) begin main_cs = 1; main_rnw = 0; main_addr = 2'd2; main_dout = 8'h01; end
            if (i == 5) begin main_cs = 0; main_rnw = 1; end
            tick();
        end
        // reload at i==4 restarts the count: 5 + RSTLEN cycles high in total
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (snd_rst !== 1'b1) begin n_fail++; $display("FAIL srst_reload[%0d]: snd_rst=%b expected 1", i, snd_rst); end
            tick();
        end
        n_checks++; if (snd_rst !== 1'b0) begin n_fail++; $display("FAIL srst_end: snd_rst=%b expected 0", snd_rst); end
        n_checks++; if (snd_nmi_n !== 1'b1) begin n_fail++; $display("FAIL srst_nmi: snd_nmi_n=%b expected 1", snd_nmi_n); end
        snd_rd(2'd3, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL srst_flags: snd_din=%h expected 00", d); end
        snd_rd(2'd0, d);
        n_checks++; if (d !== 8'h99) begin n_fail++; $display("FAIL srst_latch: snd_din=%h expected 99", d); end
        main_wr(2'd0, 8'hAA);
        tick();
        n_checks++; if (snd_nmi_n !== 1'b1) begin n_fail++; $display("FAIL srst_nmi_en: snd_nmi_n=%b expected 1", snd_nmi_n); end
        snd_rd(2'd0, d);
    endtask

    task automatic test_reset_mid_access();
        logic [7:0] d;
        main_cs = 1; main_rnw = 0; main_addr = 2'd0; main_dout = 8'hAB;
        tick();
        rst = 1;
        tick();
        rst = 0; main_dout = 8'hCD;
        tick();
        main_cs = 0; main_rnw = 1;
        tick();
        main_rd(2'd1, d);
        n_checks++; if (d !== 8'h01) begin n_fail++; $display("FAIL rst_mid_status: main_din=%h expected 01", d); end
        snd_rd(2'd0, d);
        n_checks++; if (d !== 8'hCD) begin n_fail++; $display("FAIL rst_mid_data: snd_din=%h expected cd", d); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 2) == 0) begin
                main_cs = 1'($urandom_range(0, 1)); main_rnw = 1'($urandom_range(0, 1));
                main_addr = 2'($urandom_range(0, 3)); main_dout = 8'($urandom);
                if (main_addr == 2'd2 && $urandom_range(0, 3) != 0) main_dout[0] = 1'b0;
            end
            if ($urandom_range(0, 2) == 0) begin
                snd_cs = 1'($urandom_range(0, 1)); snd_rnw = 1'($urandom_range(0, 1));
                snd_addr = 2'($urandom_range(0, 3)); snd_dout = 8'($urandom);
            end
            #1;
            n_checks++; if (main_din !== exp_main_din()) begin n_fail++; $display("FAIL rnd_main_din[%0d]: got %h expected %h", i, main_din, exp_main_din()); end
            n_checks++; if (snd_din !== exp_snd_din()) begin n_fail++; $display("FAIL rnd_snd_din[%0d]: got %h expected %h", i, snd_din, exp_snd_din()); end
            n_checks++; if (snd_nmi_n !== m_nmi_n) begin n_fail++; $display("FAIL rnd_nmi[%0d]: got %b expected %b", i, snd_nmi_n, m_nmi_n); end
            n_checks++; if (snd_rst !== (m_cnt != 0)) begin n_fail++; $display("FAIL rnd_rst[%0d]: got %b expected %b", i, snd_rst, (m_cnt != 0)); end
            tick();
        end
        rst = 0; main_cs = 0; snd_cs = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_cmd_nmi();
        test_overrun();
        test_nmi_disable();
        test_back_to_back();
        test_hold_and_snd_reset();
        test_reset_mid_access();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
